// File: rtl/load_bus_arbiter_if.sv
// Bus between the tile loaders and the load bus arbiter.
// The master side belongs to the loaders; the slave side is the arbiter.
interface load_bus_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int IDW     = 2
);
    logic               arb_en;
    logic [NUM_REQ-1:0] load_req;
    logic [NUM_REQ-1:0] load_done;
    logic [NUM_REQ-1:0] load_granted;
    logic [IDW-1:0]     bus_owner;
    logic               bus_busy;
    logic               timeout_err;
    logic [IDW-1:0]     timeout_id;
    logic               err_clr;

    modport master (
        output arb_en, load_req, load_done, err_clr,
        input  load_granted, bus_owner, bus_busy, timeout_err, timeout_id
    );

    modport slave (
        input  arb_en, load_req, load_done, err_clr,
        output load_granted, bus_owner, bus_busy, timeout_err, timeout_id
    );
endinterface

// File: rtl/load_bus_arbiter.sv
// Round-robin owner selection for the shared ICB master port, with a
// per-ownership watchdog that force-releases a stuck loader.
module load_bus_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    load_bus_arbiter_if.slave   bus_if
);
    localparam int              IDW       = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ);
    localparam logic [IDW:0]    NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam bit              WDOG_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] granted_q, granted_d;
    logic               busy_q, busy_d;
    logic               terr_q, terr_d;
    logic [IDW-1:0]     tid_q, tid_d;

    logic [2*NUM_REQ-1:0] req_rot_s;
    logic [IDW:0]         cand_s;
    logic [IDW:0]         own_inc_s;
    logic [IDW-1:0]       pick_idx_s;
    logic                 pick_found_s;
    logic [IDW-1:0]       rr_next_s;
    logic [NUM_REQ-1:0]   done_vec_s;
    logic                 done_own_s;
    logic                 hold_hit_s;
    logic                 force_rel_s;

    // Round-robin pick: first requester at or after rr_q, lowest offset wins.
    always_comb begin
        req_rot_s    = {bus_if.load_req, bus_if.load_req} >> rr_q;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s = {1'b0, rr_q} + (IDW+1)'(i);
            if (cand_s >= NUM_REQ_W) begin
                cand_s = cand_s - NUM_REQ_W;
            end else begin
                cand_s = cand_s;
            end
            if (req_rot_s[i]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[IDW-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Owner-related decode: pointer successor, owner's done, watchdog expiry.
    always_comb begin
        own_inc_s  = {1'b0, owner_q} + (IDW+1)'(1);
        rr_next_s  = (own_inc_s >= NUM_REQ_W) ? '0 : own_inc_s[IDW-1:0];
        done_vec_s = bus_if.load_done >> owner_q;
        done_own_s = done_vec_s[0];
        hold_hit_s = WDOG_EN && (cnt_q == HOLD_LAST);
    end

    // Ownership FSM; the counter counts cycles of the current ownership from the grant cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        granted_d   = '0;
        busy_d      = busy_q;
        force_rel_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (bus_if.arb_en && pick_found_s) begin
                    state_d   = ST_GRANT;
                    owner_d   = pick_idx_s;
                    granted_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT, ST_BUSY: begin
                if (state_q == ST_GRANT) begin
                    rr_d = rr_next_s;
                end else begin
                    rr_d = rr_q;
                end
                if (done_own_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (hold_hit_s) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    force_rel_s = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky timeout flag; a clear in the same cycle as a timeout wins.
    always_comb begin
        terr_d = terr_q;
        tid_d  = tid_q;
        if (bus_if.err_clr) begin
            terr_d = 1'b0;
            tid_d  = '0;
        end else if (force_rel_s && !terr_q) begin
            terr_d = 1'b1;
            tid_d  = owner_q;
        end else begin
            terr_d = terr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            granted_q <= '0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
            tid_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            granted_q <= granted_d;
            busy_q    <= busy_d;
            terr_q    <= terr_d;
            tid_q     <= tid_d;
        end
    end

    assign bus_if.load_granted = granted_q;
    assign bus_if.bus_owner    = owner_q;
    assign bus_if.bus_busy     = busy_q;
    assign bus_if.timeout_err  = terr_q;
    assign bus_if.timeout_id   = tid_q;
endmodule

// File: tb/tb_load_bus_arbiter.sv
// Directed vector table for load_bus_arbiter (NUM_REQ=3, MAX_HOLD=8) plus a
// hand-written mid-ownership reset sequence.
module tb_load_bus_arbiter;
    logic clk;
    logic rst_n;

    load_bus_arbiter_if #(.NUM_REQ(3), .IDW(2)) bus_if ();

    load_bus_arbiter #(.NUM_REQ(3), .MAX_HOLD(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] done;
        logic       en;
        logic       clr;
        logic [2:0] g;
        logic       b;
        logic [1:0] o;
        logic       e;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    function automatic void add(int n, logic [2:0] req, logic [2:0] done, logic en, logic clr,
                                logic [2:0] g, logic b, logic [1:0] o, logic e, logic [1:0] id);
        vec_t v;
        v = '{req: req, done: done, en: en, clr: clr, g: g, b: b, o: o, e: e, id: id};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [2:0] g, logic b, logic [1:0] o, logic e, logic [1:0] id);
        logic [8:0] act;
        logic [8:0] exp;
        act = {bus_if.load_granted, bus_if.bus_busy, bus_if.bus_owner, bus_if.timeout_err, bus_if.timeout_id};
        exp = {g, b, o, e, id};
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got granted=%b busy=%b owner=%0d terr=%b tid=%0d, want granted=%b busy=%b owner=%0d terr=%b tid=%0d",
                     name, act[8:6], act[5], act[4:3], act[2], act[1:0], g, b, o, e, id);
        end
    endtask

    task automatic drive(logic [2:0] req, logic [2:0] done, logic en, logic clr);
        bus_if.load_req  = req;
        bus_if.load_done = done;
        bus_if.arb_en    = en;
        bus_if.err_clr   = clr;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        drive(3'b000, 3'b000, 1'b1, 1'b0);

        // Round robin from a fresh pointer, done in the third cycle of each ownership.
        add(1, 3'b111, 3'b000, 1, 0, 3'b001, 1, 2'd0, 0, 2'd0);
        add(2, 3'b111, 3'b000, 1, 0, 3'b000, 1, 2'd0, 0, 2'd0);
        add(1, 3'b111, 3'b001, 1, 0, 3'b000, 0, 2'd0, 0, 2'd0);
        add(1, 3'b111, 3'b000, 1, 0, 3'b010, 1, 2'd1, 0, 2'd0);
        add(2, 3'b111, 3'b000, 1, 0, 3'b000, 1, 2'd1, 0, 2'd0);
        add(1, 3'b111, 3'b010, 1, 0, 3'b000, 0, 2'd1, 0, 2'd0);
        add(1, 3'b111, 3'b000, 1, 0, 3'b100, 1, 2'd2, 0, 2'd0);
        add(2, 3'b111, 3'b000, 1, 0, 3'b000, 1, 2'd2, 0, 2'd0);
        add(1, 3'b111, 3'b100, 1, 0, 3'b000, 0, 2'd2, 0, 2'd0);
        add(1, 3'b111, 3'b000, 1, 0, 3'b001, 1, 2'd0, 0, 2'd0);
        add(2, 3'b111, 3'b000, 1, 0, 3'b000, 1, 2'd0, 0, 2'd0);
        add(1, 3'b111, 3'b001, 1, 0, 3'b000, 0, 2'd0, 0, 2'd0);
        add(1, 3'b111, 3'b000, 1, 0, 3'b010, 1, 2'd1, 0, 2'd0);
        // Done in the grant cycle, then non-owner done and done while idle.
        add(1, 3'b111, 3'b010, 1, 0, 3'b000, 0, 2'd1, 0, 2'd0);
        add(1, 3'b111, 3'b000, 1, 0, 3'b100, 1, 2'd2, 0, 2'd0);
        add(1, 3'b000, 3'b000, 1, 0, 3'b000, 1, 2'd2, 0, 2'd0);
        add(1, 3'b000, 3'b001, 1, 0, 3'b000, 1, 2'd2, 0, 2'd0);
        add(1, 3'b000, 3'b100, 1, 0, 3'b000, 0, 2'd2, 0, 2'd0);
        add(1, 3'b000, 3'b111, 1, 0, 3'b000, 0, 2'd2, 0, 2'd0);
        // Single requester.
        add(1, 3'b001, 3'b000, 1, 0, 3'b001, 1, 2'd0, 0, 2'd0);
        add(2, 3'b000, 3'b000, 1, 0, 3'b000, 1, 2'd0, 0, 2'd0);
        add(1, 3'b000, 3'b001, 1, 0, 3'b000, 0, 2'd0, 0, 2'd0);
        add(1, 3'b000, 3'b000, 1, 0, 3'b000, 0, 2'd0, 0, 2'd0);
        // arb_en low during ownership of loader 2, pending 011.
        add(1, 3'b100, 3'b000, 1, 0, 3'b100, 1, 2'd2, 0, 2'd0);
        add(2, 3'b011, 3'b000, 0, 0, 3'b000, 1, 2'd2, 0, 2'd0);
        add(1, 3'b011, 3'b100, 0, 0, 3'b000, 0, 2'd2, 0, 2'd0);
        add(2, 3'b011, 3'b000, 0, 0, 3'b000, 0, 2'd2, 0, 2'd0);
        add(1, 3'b011, 3'b000, 1, 0, 3'b001, 1, 2'd0, 0, 2'd0);
        add(1, 3'b000, 3'b001, 1, 0, 3'b000, 0, 2'd0, 0, 2'd0);
        // Watchdog: owner 1 holds 8 cycles, forced release, then clear.
        add(1, 3'b010, 3'b000, 1, 0, 3'b010, 1, 2'd1, 0, 2'd0);
        add(7, 3'b000, 3'b000, 1, 0, 3'b000, 1, 2'd1, 0, 2'd0);
        add(1, 3'b000, 3'b000, 1, 0, 3'b000, 0, 2'd1, 1, 2'd1);
        add(1, 3'b000, 3'b000, 1, 0, 3'b000, 0, 2'd1, 1, 2'd1);
        add(1, 3'b000, 3'b000, 1, 1, 3'b000, 0, 2'd1, 0, 2'd0);
        // First timeout id sticks across a second timeout.
        add(1, 3'b001, 3'b000, 1, 0, 3'b001, 1, 2'd0, 0, 2'd0);
        add(7, 3'b000, 3'b000, 1, 0, 3'b000, 1, 2'd0, 0, 2'd0);
        add(1, 3'b000, 3'b000, 1, 0, 3'b000, 0, 2'd0, 1, 2'd0);
        add(1, 3'b100, 3'b000, 1, 0, 3'b100, 1, 2'd2, 1, 2'd0);
        add(7, 3'b000, 3'b000, 1, 0, 3'b000, 1, 2'd2, 1, 2'd0);
        add(1, 3'b000, 3'b000, 1, 0, 3'b000, 0, 2'd2, 1, 2'd0);
        // Clear coinciding with a timeout: the clear wins.
        add(1, 3'b010, 3'b000, 1, 0, 3'b010, 1, 2'd1, 1, 2'd0);
        add(7, 3'b000, 3'b000, 1, 0, 3'b000, 1, 2'd1, 1, 2'd0);
        add(1, 3'b000, 3'b000, 1, 1, 3'b000, 0, 2'd1, 0, 2'd0);

        repeat (2) @(negedge clk);
        check("reset_held", 3'b000, 1'b0, 2'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_idle", 3'b000, 1'b0, 2'd0, 1'b0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].done, vecs[i].en, vecs[i].clr);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].o, vecs[i].e, vecs[i].id);
        end

        // Grant loader 0 (pointer moves to 1), then reset in the middle of BUSY.
        drive(3'b001, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_pre_grant", 3'b001, 1'b1, 2'd0, 1'b0, 2'd0);
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_pre_busy", 3'b000, 1'b1, 2'd0, 1'b0, 2'd0);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 3'b000, 1'b0, 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b011, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_rr_ptr", 3'b001, 1'b1, 2'd0, 1'b0, 2'd0);
        drive(3'b000, 3'b001, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_release", 3'b000, 1'b0, 2'd0, 1'b0, 2'd0);
        drive(3'b010, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_req010", 3'b010, 1'b1, 2'd1, 1'b0, 2'd0);
        drive(3'b000, 3'b000, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
